// File: rtl/alu_exec_unit.sv
// Purpose: two-stage pipelined ALU execution unit with a 3-entry in-order response FIFO.
// Latency: a request accepted at edge E (FIFO empty) shows rsp_valid=1 after edge E+1.
// Backpressure: req_ready is decoded from registered occupancy only (fifo_count + s1_valid <= 2).
// Optional: define ALU_EXEC_STATS_EN to add the op_count / ovf_count statistics ports.

`ifndef c_ADD
`define c_ADD  3'd0
`endif
`ifndef c_SUB
`define c_SUB  3'd1
`endif
`ifndef c_SLT
`define c_SLT  3'd2
`endif
`ifndef c_XOR
`define c_XOR  3'd3
`endif
`ifndef c_NAND
`define c_NAND 3'd4
`endif
`ifndef c_AND
`define c_AND  3'd5
`endif
`ifndef c_NOR
`define c_NOR  3'd6
`endif
`ifndef c_OR
`define c_OR   3'd7
`endif

// Purpose: combinational n-bit ALU (add/sub/slt and bitwise ops) with carry, zero, overflow.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; outputs follow inputs.
module alu #(
    parameter int n = 32
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic [2:0]   cmd,
    output logic [n-1:0] result,
    output logic         carryout,
    output logic         zero,
    output logic         overflow
);

    logic         sub_op;
    logic [n-1:0] b_eff;
    logic [n:0]   sum_full;
    logic         add_ovf;
    logic         slt_bit;

    // Shared adder: SUB and SLT both compute a + ~b + 1; SLT uses sign xor overflow.
    always_comb begin
        sub_op   = (cmd == `c_SUB) || (cmd == `c_SLT);
        b_eff    = sub_op ? ~b : b;
        sum_full = {1'b0, a} + {1'b0, b_eff} + {{n{1'b0}}, sub_op};
        add_ovf  = (a[n-1] == b_eff[n-1]) && (sum_full[n-1] != a[n-1]);
        slt_bit  = sum_full[n-1] ^ add_ovf;
    end

    // Result / flag selection; SLT still reports the raw subtract flags here.
    always_comb begin
        result   = '0;
        carryout = 1'b0;
        overflow = 1'b0;
        case (cmd)
            `c_ADD, `c_SUB: begin
                result   = sum_full[n-1:0];
                carryout = sum_full[n];
                overflow = add_ovf;
            end
            `c_SLT: begin
                result   = {{(n-1){1'b0}}, slt_bit};
                carryout = sum_full[n];
                overflow = add_ovf;
            end
            `c_XOR:  result = a ^ b;
            `c_NAND: result = ~(a & b);
            `c_AND:  result = a & b;
            `c_NOR:  result = ~(a | b);
            `c_OR:   result = a | b;
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// Purpose: request/response wrapper around alu: stage-1 operand register, stage-2 evaluate into FIFO.
// Latency: accept at edge E -> response at FIFO head after edge E+1 (when FIFO empty).
// Backpressure: rsp_ready=0 fills the 3-entry FIFO; req_ready drops once occupancy would exceed it.
module alu_exec_unit #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [n-1:0] req_a,
    input  logic [n-1:0] req_b,
    input  logic [2:0]   req_cmd,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [n-1:0] rsp_result,
    output logic         rsp_carryout,
    output logic         rsp_zero,
    output logic         rsp_overflow,
    output logic [2:0]   rsp_cmd
`ifdef ALU_EXEC_STATS_EN
    ,
    output logic [15:0]  op_count,
    output logic [15:0]  ovf_count
`endif
);

    typedef struct packed {
        logic [n-1:0] result;
        logic         carryout;
        logic         zero;
        logic         overflow;
        logic [2:0]   cmd;
    } rsp_ent_t;

    // Stage 1 operand registers
    logic         s1_valid;
    logic [n-1:0] s1_a;
    logic [n-1:0] s1_b;
    logic [2:0]   s1_cmd;

    // ALU outputs (stage 2)
    logic [n-1:0] alu_result;
    logic         alu_carryout;
    logic         alu_zero;
    logic         alu_overflow;

    // Response FIFO
    rsp_ent_t     fifo_mem [3];
    logic [1:0]   wr_ptr;
    logic [1:0]   rd_ptr;
    logic [1:0]   fifo_count;
    rsp_ent_t     s2_ent;
    rsp_ent_t     head;

    logic         req_fire;
    logic         push;
    logic         pop;
    logic         is_arith;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    alu #(.n(n)) u_alu (
        .a        (s1_a),
        .b        (s1_b),
        .cmd      (s1_cmd),
        .result   (alu_result),
        .carryout (alu_carryout),
        .zero     (alu_zero),
        .overflow (alu_overflow)
    );

    // Handshake decode; req_ready depends only on registered occupancy.
    // Occupancy never exceeds 3 while s1 holds data, so a stage-1 push always finds room.
    always_comb begin
        req_ready = ({1'b0, fifo_count} + {2'b00, s1_valid}) <= 3'd2;
        rsp_valid = (fifo_count != 2'd0);
        req_fire  = req_valid && req_ready;
        pop       = rsp_valid && rsp_ready;
        push      = s1_valid;
    end

    // Stage 2 packing: carry/overflow only meaningful for ADD/SUB, masked otherwise.
    always_comb begin
        is_arith        = (s1_cmd == `c_ADD) || (s1_cmd == `c_SUB);
        s2_ent.result   = alu_result;
        s2_ent.carryout = is_arith && alu_carryout;
        s2_ent.zero     = alu_zero;
        s2_ent.overflow = is_arith && alu_overflow;
        s2_ent.cmd      = s1_cmd;
    end

    // Stage 1 register: capture operands on acceptance, retire them into the FIFO next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_cmd   <= '0;
        end else begin
            s1_valid <= req_fire;
            if (req_fire) begin
                s1_a   <= req_a;
                s1_b   <= req_b;
                s1_cmd <= req_cmd;
            end
        end
    end

    // FIFO storage write; contents need no reset because outputs are gated by rsp_valid.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_mem[wr_ptr] <= s2_ent;
        end
    end

    // FIFO pointers (modulo 3) and occupancy; push+pop together leaves count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_count <= 2'd0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Response payload: FIFO head while valid, all-zero otherwise.
    always_comb begin
        head         = fifo_mem[rd_ptr];
        rsp_result   = rsp_valid ? head.result : '0;
        rsp_carryout = rsp_valid && head.carryout;
        rsp_zero     = rsp_valid && head.zero;
        rsp_overflow = rsp_valid && head.overflow;
        rsp_cmd      = rsp_valid ? head.cmd : 3'd0;
    end

`ifdef ALU_EXEC_STATS_EN
    // Statistics: consumed responses (wrapping) and consumed overflows (saturating).
    always_ff @(posedge clk) begin
        if (reset) begin
            op_count  <= 16'd0;
            ovf_count <= 16'd0;
        end else if (pop) begin
            op_count <= op_count + 16'd1;
            if (rsp_overflow && (ovf_count != 16'hFFFF)) begin
                ovf_count <= ovf_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: reset state, per-op results/flags, latency,
// FIFO backpressure/ordering, mid-flight reset, and optional statistics counters.
module tb_alu_exec_unit;

    localparam logic [2:0] C_ADD  = 3'd0;
    localparam logic [2:0] C_SUB  = 3'd1;
    localparam logic [2:0] C_SLT  = 3'd2;
    localparam logic [2:0] C_XOR  = 3'd3;
    localparam logic [2:0] C_NAND = 3'd4;
    localparam logic [2:0] C_AND  = 3'd5;
    localparam logic [2:0] C_NOR  = 3'd6;
    localparam logic [2:0] C_OR   = 3'd7;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [2:0]  req_cmd;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_carryout;
    logic        rsp_zero;
    logic        rsp_overflow;
    logic [2:0]  rsp_cmd;
`ifdef ALU_EXEC_STATS_EN
    logic [15:0] op_count;
    logic [15:0] ovf_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    alu_exec_unit #(.n(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_cmd      (req_cmd),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_carryout (rsp_carryout),
        .rsp_zero     (rsp_zero),
        .rsp_overflow (rsp_overflow),
        .rsp_cmd      (rsp_cmd)
`ifdef ALU_EXEC_STATS_EN
        ,
        .op_count     (op_count),
        .ovf_count    (ovf_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request with rsp_ready high: checks latency, payload, then drain.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] cmd, input logic [31:0] er, input logic ec,
                         input logic ez, input logic eo);
        req_a     = a;
        req_b     = b;
        req_cmd   = cmd;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        check({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        check({tag, ".not_yet_valid"}, {31'd0, rsp_valid}, 32'd0);
        tick();
        check({tag, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, ".result"}, rsp_result, er);
        check({tag, ".carryout"}, {31'd0, rsp_carryout}, {31'd0, ec});
        check({tag, ".zero"}, {31'd0, rsp_zero}, {31'd0, ez});
        check({tag, ".overflow"}, {31'd0, rsp_overflow}, {31'd0, eo});
        check({tag, ".cmd"}, {29'd0, rsp_cmd}, {29'd0, cmd});
        tick();
        check({tag, ".drained"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          nxt;
        int          acc;
        int          got;
        logic        fire;
        logic [31:0] res_q[$];

        reset     = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_a     = 32'd0;
        req_b     = 32'd0;
        req_cmd   = C_ADD;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst.req_ready", {31'd0, req_ready}, 32'd1);
        check("rst.result", rsp_result, 32'd0);
        check("rst.flags", {29'd0, rsp_carryout, rsp_zero, rsp_overflow}, 32'd0);
        check("rst.cmd", {29'd0, rsp_cmd}, 32'd0);
`ifdef ALU_EXEC_STATS_EN
        check("rst.op_count", {16'd0, op_count}, 32'd0);
        check("rst.ovf_count", {16'd0, ovf_count}, 32'd0);
`endif

        // Per-operation directed vectors
        do_op("add_wrap",  32'hFFFFFFFF, 32'h00000001, C_ADD,  32'h00000000, 1'b1, 1'b1, 1'b0);
        do_op("add_ovf",   32'h7FFFFFFF, 32'h00000001, C_ADD,  32'h80000000, 1'b0, 1'b0, 1'b1);
        do_op("sub_ovf",   32'h20000000, 32'hA0000000, C_SUB,  32'h80000000, 1'b0, 1'b0, 1'b1);
        do_op("sub_eq",    32'hF0000000, 32'hF0000000, C_SUB,  32'h00000000, 1'b1, 1'b1, 1'b0);
        do_op("slt_neg",   32'hFFFFFFFA, 32'hFFFFFFFD, C_SLT,  32'h00000001, 1'b0, 1'b0, 1'b0);
        do_op("slt_pos",   32'h00000007, 32'h00000002, C_SLT,  32'h00000000, 1'b0, 1'b1, 1'b0);
        do_op("xor",       32'hF0F0F0F0, 32'hFF00FF00, C_XOR,  32'h0FF00FF0, 1'b0, 1'b0, 1'b0);
        do_op("nand",      32'hFFFFFFFF, 32'hFFFFFFFF, C_NAND, 32'h00000000, 1'b0, 1'b1, 1'b0);
        do_op("and",       32'hFFFF0000, 32'h0F0F0F0F, C_AND,  32'h0F0F0000, 1'b0, 1'b0, 1'b0);
        do_op("nor",       32'h00000000, 32'h00000000, C_NOR,  32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        do_op("or",        32'h00001234, 32'h00000F00, C_OR,   32'h00001F34, 1'b0, 1'b0, 1'b0);

        // Backpressure: five back-to-back ADDs with rsp_ready low
        rsp_ready = 1'b0;
        nxt = 1;
        acc = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            req_valid = 1'b1;
            req_a     = 32'(nxt);
            req_b     = 32'(nxt);
            req_cmd   = C_ADD;
            fire      = req_ready;
            if (fire) acc++;
            tick();
            if (fire) nxt++;
        end
        check("bp.accepted", 32'(acc), 32'd3);
        check("bp.req_ready_low", {31'd0, req_ready}, 32'd0);
        check("bp.rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("bp.head", rsp_result, 32'd2);
        tick();
        check("bp.head_hold", rsp_result, 32'd2);
        check("bp.still_full", {31'd0, req_ready}, 32'd0);

        rsp_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
            if (rsp_valid) begin
                res_q.push_back(rsp_result);
                got++;
            end
            req_valid = (nxt <= 5);
            req_a     = 32'(nxt);
            req_b     = 32'(nxt);
            fire      = req_valid && req_ready;
            tick();
            if (fire) nxt++;
        end
        req_valid = 1'b0;
        tick();
        check("bp.count", 32'(res_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp.order%0d", i),
                  (i < res_q.size()) ? res_q[i] : 32'hDEADBEEF, 32'(2 * (i + 1)));
        end
        check("bp.no_dup", {31'd0, rsp_valid}, 32'd0);

        // Mid-flight reset: two buffered, one in stage 1
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_a     = 32'(101 + i);
            req_b     = 32'd1;
            req_cmd   = C_ADD;
            tick();
        end
        check("mrst.setup_valid", {31'd0, rsp_valid}, 32'd1);
        check("mrst.setup_full", {31'd0, req_ready}, 32'd0);
        reset     = 1'b1;
        req_valid = 1'b1;
        req_a     = 32'd50;
        req_b     = 32'd50;
        rsp_ready = 1'b1;
        tick();
        reset     = 1'b0;
        req_valid = 1'b0;
        check("mrst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mrst.req_ready", {31'd0, req_ready}, 32'd1);
        check("mrst.result", rsp_result, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("mrst.no_stale%0d", i), {31'd0, rsp_valid}, 32'd0);
        end
        do_op("mrst.after", 32'd5, 32'd6, C_ADD, 32'd11, 1'b0, 1'b0, 1'b0);

`ifdef ALU_EXEC_STATS_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("stats.cleared", {op_count, ovf_count}, 32'd0);
        do_op("stats.a", 32'h7FFFFFFF, 32'h00000001, C_ADD, 32'h80000000, 1'b0, 1'b0, 1'b1);
        do_op("stats.b", 32'h00000001, 32'h00000001, C_ADD, 32'h00000002, 1'b0, 1'b0, 1'b0);
        do_op("stats.c", 32'h20000000, 32'hA0000000, C_SUB, 32'h80000000, 1'b0, 1'b0, 1'b1);
        do_op("stats.d", 32'h0000000F, 32'h000000F0, C_OR,  32'h000000FF, 1'b0, 1'b0, 1'b0);
        check("stats.op_count", {16'd0, op_count}, 32'd4);
        check("stats.ovf_count", {16'd0, ovf_count}, 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("stats.reset", {op_count, ovf_count}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
